booth_r4_mul_seq: RTL and testbench
===================================

// Module: booth_r4_mul_seq
// PURPOSE
//   Sequential, parametrised radix-4 Booth multiplier for the CPU ALU. It retires one Booth digit
//   per clock and returns a 2*WIDTH product split into hi/lo, ready for the HI/LO registers.
//   Supports signed and unsigned operands and uses a start/busy/done handshake toward the control unit.
// PARAMETERS
//   WIDTH  32  operand width; must be even and >= 4; product is 2*WIDTH bits
// PORTS
//   clock        in   1      single clock; all state updates on the rising edge
//   resetn       in   1      asynchronous, active-low reset
//   start        in   1      request; sampled only in IDLE or DONE
//   signed_mode  in   1      1: a and b are two's complement; 0: both unsigned; sampled with start
//   a            in   WIDTH  multiplicand; sampled with start
//   b            in   WIDTH  multiplier; sampled with start
//   busy         out  1      high while an operation is in RUN
//   done         out  1      one-cycle pulse when hi/lo become valid
//   hi           out  WIDTH  product[2*WIDTH-1:WIDTH]; held until the next accepted start
//   lo           out  WIDTH  product[WIDTH-1:0]; held until the next accepted start
// BEHAVIOUR
//   - Reset (async, resetn=0): state IDLE; busy=0, done=0, hi=0, lo=0; counter and accumulator cleared.
//     Asserting reset mid-RUN abandons the operation and sets no done.
//   - FSM states and transitions:
//       IDLE -start-> RUN;  RUN -(last digit)-> DONE;  DONE -start-> RUN;  DONE -!start-> IDLE.
//     start is ignored in RUN; operands are not re-sampled.
//   - Load on the accepting edge:
//       multiplier is extended to WIDTH+2 bits (sign-extended if signed_mode, else zero-extended)
//       and gets an appended LSB 0.
//       Multiplicand is extended the same way to WIDTH+2 bits.
//       Digit count ITER = WIDTH/2+1, so unsigned and signed use the same count.
//   - Each RUN edge handles one digit:
//       decode triplet {m[i+1],m[i],m[i-1]}: 000/111 -> 0, 001/010 -> +M, 011 -> +2M, 100 -> -2M, 101/110 -> -M.
//       The partial product (WIDTH+2 bits, two's complement) is added into the accumulator's upper
//       part, then the accumulator is arithmetically shifted right 2 and the multiplier shifted right 2.
//   - Latency: edge E0 accepts start (busy=1). Edges E1..E17 process digits (WIDTH=32).
//     After E17: state DONE, busy=0, done=1, hi/lo valid. After E18, done=0.
//     So done appears ITER cycles after the accepting edge.
//   - Result is exact modulo 2^(2*WIDTH) in both modes; there is no overflow flag.
//     Corner case: signed most-negative * most-negative is exact, e.g. 0x80000000^2 = 0x40000000_00000000.
//   - hi/lo update only on entry to DONE; they hold their old values while busy.
//   - start in DONE is accepted in the same cycle done is high (back-to-back operations, no bubble).
// CONFIGURATION
//   EARLY_TERM_EN
//     Defined: in RUN, if all remaining unprocessed multiplier bits, including the pending LSB,
//       are all 0 or all 1, the remaining digits are zero. The FSM then jumps to DONE on that edge
//       after applying the final alignment shift of 2*(remaining digits).
//       Latency becomes variable, from 1 to ITER cycles; e.g. b=0 gives done 1 cycle after start.
//       Results are bit-identical to the non-EARLY_TERM_EN build.
//     Undefined: latency is always exactly ITER cycles.
// STRUCTURE
//   - Shared include mul_defs.vh: FSM state encodings (IDLE/RUN/DONE), Booth digit codes
//     (ZERO/P1/P2/M1/M2), and the macro ITER(W) = W/2+1.
//   - Sub-module booth_r4_digit: combinational; inputs triplet and extended multiplicand,
//     output WIDTH+2-bit partial product. Instantiated once.
//   - Top level: FSM, counter ($clog2(ITER+1) bits), accumulator/multiplier shift registers,
//     and the hi/lo output registers.
// TESTING (WIDTH=32)
//   1. Unsigned: a=0xFFFFFFFF, b=0xFFFFFFFF, signed_mode=0
//      -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 17 cycles after start (without EARLY_TERM_EN).
//   2. Signed: a=7, b=0xFFFFFFFD (-3)
//      -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Also a=b=0x80000000 -> hi=0x40000000, lo=0.
//   3. Same a=b=0xFFFFFFFF in both modes
//      -> signed_mode=1 gives hi=0, lo=1; signed_mode=0 gives case 1.
//   4. Handshake: start pulsed in RUN is ignored and operands are unchanged.
//      start held high through done -> second op starts with no idle cycle, and hi/lo are stable
//      between the two dones.
//   5. Reset: drop resetn at RUN cycle 8 -> busy/done/hi/lo are 0 immediately (async).
//      After release, a new op completes correctly.
//   6. EARLY_TERM_EN: b=0 -> done 1 cycle after start, result 0.
//      b=0x00000003, a=5 -> result 15 and latency < 17. Random regression matches the non-EN build.

Source files
------------

// File: rtl/booth_r4_mul_seq_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier: FSM states, Booth digit codes,
// the digit-count helper and the triplet decoder.
package booth_r4_mul_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        DigZero = 3'd0,
        DigP1   = 3'd1,
        DigP2   = 3'd2,
        DigM1   = 3'd3,
        DigM2   = 3'd4
    } digit_e;

    // One extra digit covers the two extension bits, so signed and unsigned share a count.
    function automatic int unsigned iter_count(input int unsigned width);
        return width / 2 + 1;
    endfunction

    function automatic digit_e booth_decode(input logic [2:0] triplet);
        digit_e d;
        unique case (triplet)
            3'b000, 3'b111: d = DigZero;
            3'b001, 3'b010: d = DigP1;
            3'b011:         d = DigP2;
            3'b100:         d = DigM2;
            3'b101, 3'b110: d = DigM1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_mul_seq_digit.sv
// Combinational radix-4 Booth partial-product generator: selects 0, +-M or +-2M from a
// multiplier triplet. PP_WIDTH is the extended multiplicand width (WIDTH+2).
module booth_r4_mul_seq_digit
    import booth_r4_mul_seq_pkg::*;
#(
    parameter int unsigned PP_WIDTH = 34
) (
    input  logic [2:0]          i_triplet,
    input  logic [PP_WIDTH-1:0] i_mcand,
    output logic [PP_WIDTH-1:0] o_pp
);

    logic [PP_WIDTH-1:0] w_mcand_x2;
    digit_e              w_digit;

    // The two extension bits guarantee 2M still fits in PP_WIDTH bits.
    assign w_mcand_x2 = {i_mcand[PP_WIDTH-2:0], 1'b0};
    assign w_digit    = booth_decode(i_triplet);

    always_comb begin
        o_pp = '0;
        unique case (w_digit)
            DigZero: o_pp = '0;
            DigP1:   o_pp = i_mcand;
            DigP2:   o_pp = w_mcand_x2;
            DigM1:   o_pp = -i_mcand;
            DigM2:   o_pp = -w_mcand_x2;
            default: o_pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_mul_seq.sv
// Sequential radix-4 Booth multiplier, one digit per clock, signed/unsigned, start/busy/done.
// Optional EARLY_TERM_EN: finish as soon as the remaining multiplier digits are all zero.
module booth_r4_mul_seq
    import booth_r4_mul_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_resetn,
    input  logic             i_start,
    input  logic             i_signed_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned W2    = WIDTH + 2;
    localparam int unsigned ITER  = iter_count(WIDTH);
    localparam int unsigned CNT_W = $clog2(ITER + 1);
    localparam int unsigned AW    = W2 + 2 * ITER;

    state_e           r_state;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CNT_W-1:0] r_cnt;
    logic [W2-1:0]    r_mcand;
    logic [W2:0]      r_mplr;
    logic [AW-1:0]    r_acc;

    logic [W2-1:0]    w_a_ext;
    logic [W2-1:0]    w_b_ext;
    logic [W2-1:0]    w_pp;
    logic [W2+1:0]    w_sum;
    logic [AW-1:0]    w_acc_step;
    logic [AW-1:0]    w_acc_next;
    logic [W2:0]      w_mplr_shift;
    logic             w_last;
    logic             w_early;

    assign w_a_ext = {{2{i_signed_mode & i_a[WIDTH-1]}}, i_a};
    assign w_b_ext = {{2{i_signed_mode & i_b[WIDTH-1]}}, i_b};

    booth_r4_mul_seq_digit #(
        .PP_WIDTH (W2)
    ) u_digit (
        .i_triplet (r_mplr[2:0]),
        .i_mcand   (r_mcand),
        .o_pp      (w_pp)
    );

    // Sum is two bits wider than the partial product so the >>>2 that follows stays exact.
    assign w_sum        = {{2{r_acc[AW-1]}}, r_acc[AW-1 -: W2]} + {{2{w_pp[W2-1]}}, w_pp};
    assign w_acc_step   = {w_sum, r_acc[AW-W2-1:2]};
    assign w_mplr_shift = {{2{r_mplr[W2]}}, r_mplr[W2:2]};
    assign w_last       = (r_cnt == CNT_W'(1));

`ifdef EARLY_TERM_EN
    logic [AW-1:0] w_acc_et;

    // All-equal pending bits decode to zero digits only; apply the remaining alignment at once.
    assign w_early    = (&r_mplr) | !(|r_mplr);
    assign w_acc_et   = AW'($signed(r_acc) >>> {r_cnt, 1'b0});
    assign w_acc_next = w_early ? w_acc_et : w_acc_step;
`else
    assign w_early    = 1'b0;
    assign w_acc_next = w_acc_step;
`endif

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_acc   <= '0;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_mcand <= w_a_ext;
                        r_mplr  <= {w_b_ext, 1'b0};
                        r_acc   <= '0;
                        r_cnt   <= CNT_W'(ITER);
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StRun: begin
                    if (w_early || w_last) begin
                        r_acc   <= w_acc_next;
                        r_hi    <= w_acc_next[2*WIDTH-1:WIDTH];
                        r_lo    <= w_acc_next[WIDTH-1:0];
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_acc  <= w_acc_step;
                        r_mplr <= w_mplr_shift;
                        r_cnt  <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_booth_r4_mul_seq.sv
// Scoreboard bench for booth_r4_mul_seq: directed corners, handshake, async reset, random ops
// against a 64-bit arithmetic reference model.
module tb_booth_r4_mul_seq;

    localparam int unsigned WIDTH = 32;
    localparam int          ITER  = 17;

    logic             clk = 1'b0;
    logic             resetn = 1'b1;
    logic             start = 1'b0;
    logic             smode = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    booth_r4_mul_seq #(
        .WIDTH (WIDTH)
    ) dut (
        .i_clock       (clk),
        .i_resetn      (resetn),
        .i_start       (start),
        .i_signed_mode (smode),
        .i_a           (a),
        .i_b           (b),
        .o_busy        (busy),
        .o_done        (done),
        .o_hi          (hi),
        .o_lo          (lo)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] prod;
        int unsigned acc_cyc;
        int          exp_lat;  // 0 means "anything in 1..ITER"
    } exp_t;

    exp_t        sb[$];
    int          nrun = 0;
    int          nfail = 0;
    logic [63:0] last_prod = '0;
    bit          mon_en = 1'b0;

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic s);
        logic signed [63:0] ex;
        logic signed [63:0] ey;
        ex = s ? {{32{x[31]}}, x} : {32'b0, x};
        ey = s ? {{32{y[31]}}, y} : {32'b0, y};
        return ex * ey;
    endfunction

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        nrun++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse and checks hold/busy otherwise.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && mon_en) begin
                if (done) begin
                    check64("busy_at_done", 64'(busy), 64'd0);
                    if (sb.size() == 0) begin
                        nrun++;
                        nfail++;
                        $display("FAIL unexpected_done: got done=1 expected no pending op");
                    end else begin
                        exp_t e;
                        int   lat;
                        e   = sb.pop_front();
                        lat = int'(cyc - e.acc_cyc);
                        check64("product", {hi, lo}, e.prod);
                        if (e.exp_lat > 0) begin
                            check64("latency", 64'(lat), 64'(e.exp_lat));
                        end else begin
                            nrun++;
                            if (lat < 1 || lat > ITER) begin
                                nfail++;
                                $display("FAIL latency_range: got %0d expected 1..%0d", lat, ITER);
                            end
                        end
                        last_prod = e.prod;
                    end
                end else begin
                    check64("hold_hilo", {hi, lo}, last_prod);
                    check64("busy", 64'(busy), 64'(sb.size() != 0));
                end
            end
        end
    end

    // Waits (bounded) for a negedge with busy low, then issues one op; returns whether done was
    // high in the issuing cycle. glitch=1 pulses start with junk operands while the op runs.
    task automatic issue(input logic [31:0] xa, input logic [31:0] xb, input logic s,
                         input bit glitch, output bit was_done);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        was_done = done;
        if (busy) begin
            nrun++;
            nfail++;
            $display("FAIL busy_timeout: got busy=1 expected 0 within 200 cycles");
            was_done = 1'b0;
            return;
        end
        a     = xa;
        b     = xb;
        smode = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.prod    = ref_mul(xa, xb, s);
        e.acc_cyc = cyc;
`ifdef EARLY_TERM_EN
        e.exp_lat = (xb == 32'd0) ? 1 : 0;
`else
        e.exp_lat = ITER;
`endif
        sb.push_back(e);
        start = 1'b0;
        // Operands must not be re-sampled after acceptance.
        a     = $urandom;
        b     = $urandom;
        smode = ~s;
        if (glitch) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    logic [31:0] corners [6];
    bit          wd;

    initial begin
        corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h55555555};

        #2 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check64("reset_busy", 64'(busy), 64'd0);
        check64("reset_done", 64'(done), 64'd0);
        check64("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        mon_en = 1'b1;

        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, wd);
        issue(32'd7,        32'hFFFFFFFD, 1'b1, 1'b0, wd);
        issue(32'h80000000, 32'h80000000, 1'b1, 1'b0, wd);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, wd);
        issue(32'd5,        32'd3,        1'b0, 1'b0, wd);
        issue(32'h12345678, 32'd0,        1'b1, 1'b0, wd);
        // Start pulsed mid-run with junk operands must be ignored.
        issue(32'hDEADBEEF, 32'h40000001, 1'b0, 1'b1, wd);

        // Back-to-back: second start must land in the done cycle.
        issue(32'h0000ABCD, 32'h40000003, 1'b0, 1'b0, wd);
        issue(32'hFFFF1234, 32'h6000000F, 1'b1, 1'b0, wd);
        check64("back_to_back", 64'(wd), 64'd1);

        // Async reset mid-run abandons the op and clears outputs immediately.
        issue(32'h13579BDF, 32'h2468ACE1, 1'b0, 1'b0, wd);
        repeat (8) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check64("midrun_reset_busy", 64'(busy), 64'd0);
        check64("midrun_reset_done", 64'(done), 64'd0);
        check64("midrun_reset_hilo", {hi, lo}, 64'd0);
        sb.delete();
        last_prod = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        issue(32'hFFFFFFF9, 32'h00000006, 1'b1, 1'b0, wd);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            issue(ra, rb, 1'($urandom_range(0, 1)), 1'b0, wd);
        end

        for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
        if (sb.size() != 0) begin
            nrun++;
            nfail++;
            $display("FAIL drain: got %0d pending ops expected 0", sb.size());
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule
